// File: rtl/multi_rate_divider.sv
// multi_rate_divider: NUM_CH independent programmable tick generators.
// Each channel counts down a period P and emits a one-cycle pulse at terminal
// count, either repeatedly (periodic) or once (one-shot). A period written
// while a channel runs is held in a shadow register and adopted at the next
// terminal count, so running tick trains never see a truncated period.
module multi_rate_divider #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]  cfg_period,
  input  logic              cfg_oneshot,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] stop,
  output logic [NUM_CH-1:0] out_pulse,
  output logic [NUM_CH-1:0] running,
  output logic [NUM_CH-1:0] done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Per-channel architectural state
  state_t             r_state   [NUM_CH];
  logic [WIDTH-1:0]   r_cnt     [NUM_CH];
  logic [WIDTH-1:0]   r_act_p   [NUM_CH];
  logic [WIDTH-1:0]   r_shd_p   [NUM_CH];
  logic [NUM_CH-1:0]  r_act_os;
  logic [NUM_CH-1:0]  r_shd_os;
  logic [NUM_CH-1:0]  r_pending;
  logic [NUM_CH-1:0]  r_pulse;
  logic [NUM_CH-1:0]  r_done;

  // Next-state values
  state_t             w_state_nxt [NUM_CH];
  logic [WIDTH-1:0]   w_cnt_nxt   [NUM_CH];
  logic [WIDTH-1:0]   w_act_p_nxt [NUM_CH];
  logic [WIDTH-1:0]   w_shd_p_nxt [NUM_CH];
  logic [NUM_CH-1:0]  w_act_os_nxt;
  logic [NUM_CH-1:0]  w_shd_os_nxt;
  logic [NUM_CH-1:0]  w_pending_nxt;
  logic [NUM_CH-1:0]  w_pulse_nxt;
  logic [NUM_CH-1:0]  w_done_nxt;

  // Decoded per-channel events
  logic [WIDTH-1:0]   w_eff_p   [NUM_CH];
  logic [NUM_CH-1:0]  w_eff_os;
  logic [NUM_CH-1:0]  w_wr;
  logic [NUM_CH-1:0]  w_start_ok;
  logic [NUM_CH-1:0]  w_term;

  // Event decode: config target, effective period for a start, terminal count
  always_comb begin
    w_wr       = '0;
    w_eff_os   = '0;
    w_start_ok = '0;
    w_term     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_eff_p[c]    = r_pending[c] ? r_shd_p[c]  : r_act_p[c];
      w_eff_os[c]   = r_pending[c] ? r_shd_os[c] : r_act_os[c];
      w_wr[c]       = cfg_we && (cfg_ch == CH_W'(c));
      w_start_ok[c] = start[c] && (w_eff_p[c] != '0);
      w_term[c]     = (r_state[c] == ST_RUN) && (r_cnt[c] == '0);
    end
  end

  // State register and datapath registers; synchronous reset clears everything
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_state[c] <= ST_IDLE;
        r_cnt[c]   <= '0;
        r_act_p[c] <= '0;
        r_shd_p[c] <= '0;
      end
      r_act_os  <= '0;
      r_shd_os  <= '0;
      r_pending <= '0;
      r_pulse   <= '0;
      r_done    <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_state[c] <= w_state_nxt[c];
        r_cnt[c]   <= w_cnt_nxt[c];
        r_act_p[c] <= w_act_p_nxt[c];
        r_shd_p[c] <= w_shd_p_nxt[c];
      end
      r_act_os  <= w_act_os_nxt;
      r_shd_os  <= w_shd_os_nxt;
      r_pending <= w_pending_nxt;
      r_pulse   <= w_pulse_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Next-state and counter/period update: stop > start > terminal > decrement
  always_comb begin
    w_act_os_nxt  = r_act_os;
    w_shd_os_nxt  = r_shd_os;
    w_pending_nxt = r_pending;
    for (int c = 0; c < NUM_CH; c++) begin
      w_state_nxt[c] = r_state[c];
      w_cnt_nxt[c]   = r_cnt[c];
      w_act_p_nxt[c] = r_act_p[c];
      w_shd_p_nxt[c] = r_shd_p[c];

      if (stop[c]) begin
        w_state_nxt[c] = ST_IDLE;
        w_cnt_nxt[c]   = '0;
      end else if (w_start_ok[c]) begin
        w_state_nxt[c]   = ST_RUN;
        w_cnt_nxt[c]     = w_eff_p[c] - WIDTH'(1);
        w_act_p_nxt[c]   = w_eff_p[c];
        w_act_os_nxt[c]  = w_eff_os[c];
        w_pending_nxt[c] = 1'b0;
      end else if (w_term[c]) begin
        if (r_act_os[c]) begin
          w_state_nxt[c] = ST_IDLE;
        end else if (r_pending[c]) begin
          w_act_p_nxt[c]   = r_shd_p[c];
          w_act_os_nxt[c]  = r_shd_os[c];
          w_pending_nxt[c] = 1'b0;
          if (r_shd_p[c] != '0) begin
            w_cnt_nxt[c] = r_shd_p[c] - WIDTH'(1);
          end else begin
            w_state_nxt[c] = ST_IDLE;
          end
        end else begin
          w_cnt_nxt[c] = r_act_p[c] - WIDTH'(1);
        end
      end else if (r_state[c] == ST_RUN) begin
        w_cnt_nxt[c] = r_cnt[c] - WIDTH'(1);
      end

      // A write lands in the shadow whenever the channel is (or becomes) busy;
      // the edge's own start/terminal decisions above used the pre-edge values.
      if (w_wr[c]) begin
        w_shd_p_nxt[c]  = cfg_period;
        w_shd_os_nxt[c] = cfg_oneshot;
        if ((r_state[c] == ST_RUN) || (w_state_nxt[c] == ST_RUN)) begin
          w_pending_nxt[c] = 1'b1;
        end else begin
          w_act_p_nxt[c]   = cfg_period;
          w_act_os_nxt[c]  = cfg_oneshot;
          w_pending_nxt[c] = 1'b0;
        end
      end
    end
  end

  // Output next values: terminal pulse unless stopped or restarted; sticky done
  always_comb begin
    w_pulse_nxt = '0;
    w_done_nxt  = r_done;
    for (int c = 0; c < NUM_CH; c++) begin
      w_pulse_nxt[c] = w_term[c] && !stop[c] && !w_start_ok[c];
      if (!stop[c]) begin
        if (w_start_ok[c]) begin
          w_done_nxt[c] = 1'b0;
        end else if (w_term[c] && r_act_os[c]) begin
          w_done_nxt[c] = 1'b1;
        end
      end
    end
  end

  // Status outputs straight from registers
  always_comb begin
    out_pulse = r_pulse;
    done      = r_done;
    running   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      running[c] = (r_state[c] == ST_RUN);
    end
  end

endmodule
